// File: rtl/lock_hd_accumulator.sv
// lock_hd_accumulator
//   Measurement stage behind the key-locked carry-lookahead adder. Each
//   accepted operand pair is checked against the locked adder's result:
//   the golden (DATA_W+1)-bit sum is XORed with result_i, and the set bits
//   of that difference are counted. Over a run of NUM_VECS vectors the
//   block reports how many vectors were wrong, the total and the largest
//   per-vector Hamming distance. There is one summary per applied key.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               begin a new run (honoured in IDLE and DONE only)
//   valid_i               triple valid; accepted when valid_i && ready_o
//   add1_i, add2_i        operands fed to the locked adder
//   result_i              locked adder output, DATA_W+1 bits
//   ready_o               high in RUN
//   busy_o                high in RUN and DRAIN
//   done_o                high in DONE until the next start_i or rst_i
//   vec_cnt_o             vectors accepted this run
//   err_cnt_o             vectors with nonzero Hamming distance
//   hd_sum_o              saturating sum of Hamming distances
//   max_hd_o              largest per-vector Hamming distance
module lock_hd_accumulator #(
  parameter int DATA_W   = 32,
  parameter int NUM_VECS = 10000,
  parameter int CNT_W    = 16,
  parameter int SUM_W    = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] add1_i,
  input  logic [DATA_W-1:0] add2_i,
  input  logic [DATA_W:0]   result_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  vec_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [SUM_W-1:0]  hd_sum_o,
  output logic [5:0]        max_hd_o
);

  localparam int RES_W = DATA_W + 1;
  localparam int HD_W  = 6;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q;
  logic              accept;
  logic              last_vec;
  logic              clear;
  logic [2:1]        vld_pipe;   // [1]: diff_q valid, [2]: hd_q valid
  logic [RES_W-1:0]  diff_d, diff_q;
  logic [HD_W-1:0]   hd_d, hd_q;
  logic [SUM_W:0]    sum_ext;

  assign accept   = valid_i && (state_q == RUN);
  assign last_vec = accept && (vec_cnt_o == CNT_W'(NUM_VECS - 1));
  assign clear    = start_i && ((state_q == IDLE) || (state_q == DONE));

  // Zero-extended golden sum so a wrong carry-out shows up as bit DATA_W.
  assign diff_d = (({1'b0, add1_i} + {1'b0, add2_i}) ^ result_i);

  always_comb begin
    hd_d = '0;
    for (int i = 0; i < RES_W; i++) hd_d = hd_d + HD_W'(diff_q[i]);
  end

  // One spare bit catches the carry out of the accumulator for saturation.
  assign sum_ext = {1'b0, hd_sum_o} + (SUM_W + 1)'(hd_q);

  // Control FSM; status outputs are registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ready_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= RUN;
          ready_o <= 1'b1;
          busy_o  <= 1'b1;
        end
        RUN: if (last_vec) begin
          state_q <= DRAIN;
          ready_o <= 1'b0;
        end
        // The last vector is still in stage 1 on entry; wait until it has
        // left stage 2 so its statistics are already folded in.
        DRAIN: if (!vld_pipe[1] && !vld_pipe[2]) begin
          state_q <= DONE;
          busy_o  <= 1'b0;
          done_o  <= 1'b1;
        end
        DONE: if (start_i) begin
          state_q <= RUN;
          ready_o <= 1'b1;
          busy_o  <= 1'b1;
          done_o  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath: stage 1 diff, stage 2 popcount, stage 3 statistics.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      vld_pipe  <= '0;
      diff_q    <= '0;
      hd_q      <= '0;
      vec_cnt_o <= '0;
      err_cnt_o <= '0;
      hd_sum_o  <= '0;
      max_hd_o  <= '0;
    end else begin
      vld_pipe[1] <= accept;
      vld_pipe[2] <= vld_pipe[1];
      if (accept) begin
        diff_q    <= diff_d;
        vec_cnt_o <= vec_cnt_o + CNT_W'(1);
      end
      if (vld_pipe[1]) hd_q <= hd_d;
      if (vld_pipe[2]) begin
        if (hd_q != '0)      err_cnt_o <= err_cnt_o + CNT_W'(1);
        if (hd_q > max_hd_o) max_hd_o  <= hd_q;
        hd_sum_o <= sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_lock_hd_accumulator.sv
module tb_lock_hd_accumulator;

  typedef struct {
    int vec;
    int err;
    int sum;
    int mx;
  } stats_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        start_s = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] add1_i = '0;
  logic [31:0] add2_i = '0;
  logic [32:0] result_i = '0;

  logic        ready_o, busy_o, done_o;
  logic [15:0] vec_cnt_o, err_cnt_o;
  logic [23:0] hd_sum_o;
  logic [5:0]  max_hd_o;

  logic        ready_s, busy_s, done_s;
  logic [15:0] vec_s, err_s;
  logic [5:0]  sum_s;
  logic [5:0]  max_s;

  int checks = 0;
  int failures = 0;
  stats_t exp_q[$];

  always #5 clk = ~clk;

  lock_hd_accumulator #(.DATA_W(32), .NUM_VECS(4), .CNT_W(16), .SUM_W(24)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .valid_i(valid_i),
    .add1_i(add1_i), .add2_i(add2_i), .result_i(result_i),
    .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o),
    .vec_cnt_o(vec_cnt_o), .err_cnt_o(err_cnt_o),
    .hd_sum_o(hd_sum_o), .max_hd_o(max_hd_o));

  lock_hd_accumulator #(.DATA_W(32), .NUM_VECS(3), .CNT_W(16), .SUM_W(6)) dut_sat (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_s), .valid_i(valid_i),
    .add1_i(add1_i), .add2_i(add2_i), .result_i(result_i),
    .ready_o(ready_s), .busy_o(busy_s), .done_o(done_s),
    .vec_cnt_o(vec_s), .err_cnt_o(err_s),
    .hd_sum_o(sum_s), .max_hd_o(max_s));

  function automatic logic [32:0] gold(logic [31:0] a, logic [31:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic stats_t model_vec(stats_t s, logic [31:0] a, logic [31:0] b,
                                       logic [32:0] r, int sum_max);
    logic [32:0] d;
    int hd;
    d = gold(a, b) ^ r;
    hd = $countones(d);
    s.vec += 1;
    if (hd != 0) s.err += 1;
    s.sum = (s.sum + hd > sum_max) ? sum_max : s.sum + hd;
    if (hd > s.mx) s.mx = hd;
    return s;
  endfunction

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic send(logic [31:0] a, logic [31:0] b, logic [32:0] r);
    valid_i = 1'b1; add1_i = a; add2_i = b; result_i = r;
    cycle();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b1;
    cycle(); cycle();
    rst_i = 1'b0; start_i = 1'b0;
    cycle();
    checks++;
    if ({ready_o, busy_o, done_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got r=%b b=%b d=%b want 000", ready_o, busy_o, done_o);
    end
    checks++;
    if (vec_cnt_o !== 0 || err_cnt_o !== 0 || hd_sum_o !== 0 || max_hd_o !== 0) begin
      failures++;
      $display("FAIL reset_stats got vec=%0d err=%0d sum=%0d max=%0d want 0", vec_cnt_o, err_cnt_o, hd_sum_o, max_hd_o);
    end
    send($urandom, $urandom, 33'h1);
    send($urandom, $urandom, 33'h0);
    valid_i = 1'b0;
    cycle(); cycle(); cycle();
    checks++;
    if (vec_cnt_o !== 0 || err_cnt_o !== 0 || busy_o !== 1'b0 || ready_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_valid_ignored got vec=%0d err=%0d busy=%b ready=%b want 0", vec_cnt_o, err_cnt_o, busy_o, ready_o);
    end
  endtask

  task automatic test_exact();
    stats_t s;
    stats_t e;
    logic [31:0] av[4];
    logic [31:0] bv[4];
    int n;
    s = '{0, 0, 0, 0};
    av[0] = 32'h12345678; bv[0] = 32'h11111111;
    av[1] = 32'h00000000; bv[1] = 32'h00000000;
    av[2] = 32'hFFFFFFFF; bv[2] = 32'hFFFFFFFF;
    av[3] = 32'h80000000; bv[3] = 32'h80000000;
    start_i = 1'b1; cycle(); start_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || vec_cnt_o !== 0) begin
      failures++;
      $display("FAIL exact_start got ready=%b vec=%0d want 1 0", ready_o, vec_cnt_o);
    end
    for (int i = 0; i < 4; i++) begin
      s = model_vec(s, av[i], bv[i], gold(av[i], bv[i]), 24'hFFFFFF);
      send(av[i], bv[i], gold(av[i], bv[i]));
    end
    valid_i = 1'b0;
    exp_q.push_back(s);
    n = 0;
    while (done_o !== 1'b1 && n < 50) begin cycle(); n++; end
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL exact_done_latency got %0d cycles want 3", n);
    end
    e = exp_q.pop_front();
    checks++;
    if (vec_cnt_o !== e.vec || err_cnt_o !== e.err || hd_sum_o !== e.sum || max_hd_o !== e.mx) begin
      failures++;
      $display("FAIL exact_stats got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               vec_cnt_o, err_cnt_o, hd_sum_o, max_hd_o, e.vec, e.err, e.sum, e.mx);
    end
  endtask

  task automatic test_hd_extremes();
    stats_t s;
    stats_t e;
    int n;
    s = '{0, 0, 0, 0};
    start_i = 1'b1; cycle(); start_i = 1'b0;
    checks++;
    if (vec_cnt_o !== 0 || ready_o !== 1'b1 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL restart_clear got vec=%0d ready=%b done=%b want 0 1 0", vec_cnt_o, ready_o, done_o);
    end
    s = model_vec(s, 32'h1, 32'h2, 33'h000000002, 24'hFFFFFF);
    send(32'h1, 32'h2, 33'h000000002);
    s = model_vec(s, 32'hFFFFFFFF, 32'h1, 33'h0FFFFFFFF, 24'hFFFFFF);
    send(32'hFFFFFFFF, 32'h1, 33'h0FFFFFFFF);
    s = model_vec(s, 32'hDEADBEEF, 32'h1234, gold(32'hDEADBEEF, 32'h1234), 24'hFFFFFF);
    send(32'hDEADBEEF, 32'h1234, gold(32'hDEADBEEF, 32'h1234));
    s = model_vec(s, 32'h7, 32'h9, gold(32'h7, 32'h9), 24'hFFFFFF);
    send(32'h7, 32'h9, gold(32'h7, 32'h9));
    valid_i = 1'b0;
    exp_q.push_back(s);
    n = 0;
    while (done_o !== 1'b1 && n < 50) begin cycle(); n++; end
    e = exp_q.pop_front();
    checks++;
    if (n >= 50 || vec_cnt_o !== e.vec || err_cnt_o !== e.err || hd_sum_o !== e.sum || max_hd_o !== e.mx) begin
      failures++;
      $display("FAIL hd_extremes got %0d/%0d/%0d/%0d wait=%0d want %0d/%0d/%0d/%0d",
               vec_cnt_o, err_cnt_o, hd_sum_o, max_hd_o, n, e.vec, e.err, e.sum, e.mx);
    end
  endtask

  task automatic test_restart();
    stats_t s;
    stats_t e;
    logic [31:0] a, b;
    logic [32:0] m;
    int n;
    s = '{0, 0, 0, 0};
    cycle(); cycle(); cycle();
    checks++;
    if (hd_sum_o !== 24'd34 || err_cnt_o !== 16'd2 || max_hd_o !== 6'd33 || done_o !== 1'b1) begin
      failures++;
      $display("FAIL done_hold got sum=%0d err=%0d max=%0d done=%b want 34 2 33 1", hd_sum_o, err_cnt_o, max_hd_o, done_o);
    end
    start_i = 1'b1; cycle(); start_i = 1'b0;
    checks++;
    if (vec_cnt_o !== 0 || err_cnt_o !== 0 || hd_sum_o !== 0 || max_hd_o !== 0 || ready_o !== 1'b1) begin
      failures++;
      $display("FAIL restart_zero got %0d/%0d/%0d/%0d ready=%b want 0/0/0/0 1", vec_cnt_o, err_cnt_o, hd_sum_o, max_hd_o, ready_o);
    end
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      m = 33'h1 << $urandom_range(0, 32);
      s = model_vec(s, a, b, gold(a, b) ^ m, 24'hFFFFFF);
      send(a, b, gold(a, b) ^ m);
    end
    valid_i = 1'b0;
    exp_q.push_back(s);
    n = 0;
    while (done_o !== 1'b1 && n < 50) begin cycle(); n++; end
    e = exp_q.pop_front();
    checks++;
    if (n >= 50 || vec_cnt_o !== e.vec || err_cnt_o !== e.err || hd_sum_o !== e.sum || max_hd_o !== e.mx) begin
      failures++;
      $display("FAIL restart_stats got %0d/%0d/%0d/%0d wait=%0d want %0d/%0d/%0d/%0d",
               vec_cnt_o, err_cnt_o, hd_sum_o, max_hd_o, n, e.vec, e.err, e.sum, e.mx);
    end
  endtask

  task automatic test_gaps();
    stats_t s;
    stats_t e;
    logic [31:0] a, b;
    logic [32:0] r;
    logic pat[7];
    int n;
    int early;
    s = '{0, 0, 0, 0};
    early = 0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    send($urandom, $urandom, 33'h1FFFFFFFF);
    send($urandom, $urandom, 33'h0);
    valid_i = 1'b0;
    cycle();
    checks++;
    if (vec_cnt_o !== 16'd4 || done_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL done_valid_ignored got vec=%0d done=%b busy=%b want 4 1 0", vec_cnt_o, done_o, busy_o);
    end
    start_i = 1'b1; cycle(); start_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a = $urandom; b = $urandom;
      r = {1'($urandom_range(0, 1)), 32'($urandom)};
      start_i = (i == 2);
      if (pat[i]) s = model_vec(s, a, b, r, 24'hFFFFFF);
      valid_i = pat[i]; add1_i = a; add2_i = b; result_i = r;
      cycle();
      if (done_o === 1'b1) early++;
    end
    valid_i = 1'b0; start_i = 1'b0;
    exp_q.push_back(s);
    n = 0;
    while (done_o !== 1'b1 && n < 50) begin cycle(); n++; end
    checks++;
    if (n != 3 || early != 0) begin
      failures++;
      $display("FAIL gaps_done got latency=%0d early=%0d want 3 0", n, early);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (done_o !== 1'b1) early++;
    end
    e = exp_q.pop_front();
    checks++;
    if (early != 0 || vec_cnt_o !== e.vec || err_cnt_o !== e.err || hd_sum_o !== e.sum || max_hd_o !== e.mx) begin
      failures++;
      $display("FAIL gaps_stats got %0d/%0d/%0d/%0d drop=%0d want %0d/%0d/%0d/%0d 0",
               vec_cnt_o, err_cnt_o, hd_sum_o, max_hd_o, early, e.vec, e.err, e.sum, e.mx);
    end
  endtask

  task automatic test_sat();
    stats_t s;
    stats_t e;
    int n;
    s = '{0, 0, 0, 0};
    start_s = 1'b1; cycle(); start_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s = model_vec(s, 32'hFFFFFFFF, 32'h1, 33'h0FFFFFFFF, 63);
      send(32'hFFFFFFFF, 32'h1, 33'h0FFFFFFFF);
    end
    valid_i = 1'b0;
    exp_q.push_back(s);
    n = 0;
    while (done_s !== 1'b1 && n < 50) begin cycle(); n++; end
    e = exp_q.pop_front();
    checks++;
    if (n != 3 || vec_s !== e.vec || err_s !== e.err || sum_s !== e.sum || max_s !== e.mx) begin
      failures++;
      $display("FAIL sat_stats got %0d/%0d/%0d/%0d wait=%0d want %0d/%0d/%0d/%0d 3",
               vec_s, err_s, sum_s, max_s, n, e.vec, e.err, e.sum, e.mx);
    end
  endtask

  task automatic test_reset_mid();
    stats_t s;
    stats_t e;
    logic [31:0] a, b;
    int n;
    s = '{0, 0, 0, 0};
    start_i = 1'b1; cycle(); start_i = 1'b0;
    send(32'h10, 32'h20, gold(32'h10, 32'h20) ^ 33'h100000001);
    send(32'h30, 32'h40, gold(32'h30, 32'h40) ^ 33'h0000000F0);
    valid_i = 1'b0; rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    checks++;
    if ({ready_o, busy_o, done_o} !== 3'b000 || vec_cnt_o !== 0 || err_cnt_o !== 0 || hd_sum_o !== 0 || max_hd_o !== 0) begin
      failures++;
      $display("FAIL midrun_reset got flags=%b stats=%0d/%0d/%0d/%0d want 000 0/0/0/0",
               {ready_o, busy_o, done_o}, vec_cnt_o, err_cnt_o, hd_sum_o, max_hd_o);
    end
    cycle(); cycle(); cycle();
    checks++;
    if (err_cnt_o !== 0 || hd_sum_o !== 0 || max_hd_o !== 0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL midrun_flush got %0d/%0d/%0d busy=%b want 0/0/0 0", err_cnt_o, hd_sum_o, max_hd_o, busy_o);
    end
    start_i = 1'b1; cycle(); start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      s = model_vec(s, a, b, gold(a, b) ^ 33'h3, 24'hFFFFFF);
      send(a, b, gold(a, b) ^ 33'h3);
    end
    valid_i = 1'b0;
    exp_q.push_back(s);
    n = 0;
    while (done_o !== 1'b1 && n < 50) begin cycle(); n++; end
    e = exp_q.pop_front();
    checks++;
    if (n != 3 || vec_cnt_o !== e.vec || err_cnt_o !== e.err || hd_sum_o !== e.sum || max_hd_o !== e.mx) begin
      failures++;
      $display("FAIL post_reset_run got %0d/%0d/%0d/%0d wait=%0d want %0d/%0d/%0d/%0d 3",
               vec_cnt_o, err_cnt_o, hd_sum_o, max_hd_o, n, e.vec, e.err, e.sum, e.mx);
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_hd_extremes();
    test_restart();
    test_gaps();
    test_sat();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
